// File: rtl/accel_channel_conditioner_if.sv
// Sample/result bus between the SPI front end, the conditioner and the display logic.
// The master drives sample strobes; the slave (conditioner) returns conditioned results.
interface accel_channel_conditioner_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIGITS = 3
);
  logic                         sample_valid;
  logic [NUM_CH*DATA_W-1:0]     sample_in;
  logic [NUM_CH*DATA_W-1:0]     mag_out;
  logic [NUM_CH-1:0]            sign_out;
  logic [NUM_CH*DIGITS*4-1:0]   bcd_out;
  logic [NUM_CH-1:0]            ovf_out;
  logic                         out_valid;
  logic                         busy;
  logic [7:0]                   drop_cnt;

  modport master (
    output sample_valid, sample_in,
    input  mag_out, sign_out, bcd_out, ovf_out, out_valid, busy, drop_cnt
  );

  modport slave (
    input  sample_valid, sample_in,
    output mag_out, sign_out, bcd_out, ovf_out, out_valid, busy, drop_cnt
  );
endinterface

// File: rtl/accel_channel_conditioner.sv
// Accelerometer channel conditioner: per-channel saturated magnitude and sign,
// moving average over 2**AVG_LOG2 samples, sequential double-dabble to BCD.
// Optional feature macro: ACCEL_DEADBAND_EN (small magnitudes forced to zero).
module accel_channel_conditioner #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned DEADBAND = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  accel_channel_conditioner_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DISP_MAX = DATA_W'(10**DIGITS - 1);

  // Elaboration sanity check on the deadband threshold
  if (DEADBAND > MAG_MAX) begin : g_deadband_range
    $error("DEADBAND exceeds the largest representable magnitude");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_FILTER, S_CONVERT, S_DONE
  } state_e;

  state_e                                      state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0]               sample_q, sample_d;
  logic [NUM_CH-1:0][DATA_W-1:0]               mag_cap_q, mag_cap_d;
  logic [NUM_CH-1:0]                           sign_cap_q, sign_cap_d;
  logic [NUM_CH-1:0][DEPTH-1:0][DATA_W-1:0]    ring_q, ring_d;
  logic [NUM_CH-1:0][SUM_W-1:0]                sum_q, sum_d;
  logic [PTR_W-1:0]                            ptr_q, ptr_d;
  logic [CH_W-1:0]                             ch_q, ch_d;
  logic [BIT_W-1:0]                            bit_q, bit_d;
  logic [DATA_W-1:0]                           bin_q, bin_d;
  logic [BCD_W-1:0]                            bcd_q, bcd_d;
  logic [NUM_CH-1:0][BCD_W-1:0]                bcd_res_q, bcd_res_d;
  logic [NUM_CH-1:0]                           ovf_res_q, ovf_res_d;
  logic [NUM_CH-1:0][DATA_W-1:0]               mag_out_q, mag_out_d;
  logic [NUM_CH-1:0]                           sign_out_q, sign_out_d;
  logic [NUM_CH-1:0][BCD_W-1:0]                bcd_out_q, bcd_out_d;
  logic [NUM_CH-1:0]                           ovf_out_q, ovf_out_d;
  logic                                        out_valid_q, out_valid_d;
  logic                                        busy_q, busy_d;
  logic [7:0]                                  drop_q, drop_d;

  logic [NUM_CH-1:0][DATA_W-1:0]               avg_c;
  logic [DATA_W-1:0]                           smp, cur_mag, old_mag, src_bin, bin_n;
  logic [BCD_W-1:0]                            src_bcd, bcd_adj, bcd_n;

  // Truncated moving average of every channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      avg_c[i] = DATA_W'(sum_q[i] >> AVG_LOG2);
    end
  end

  // Next-state, datapath and output computation
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    mag_cap_d   = mag_cap_q;
    sign_cap_d  = sign_cap_q;
    ring_d      = ring_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    bit_d       = bit_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    bcd_res_d   = bcd_res_q;
    ovf_res_d   = ovf_res_q;
    mag_out_d   = mag_out_q;
    sign_out_d  = sign_out_q;
    bcd_out_d   = bcd_out_q;
    ovf_out_d   = ovf_out_q;
    drop_d      = drop_q;
    smp         = '0;
    cur_mag     = '0;
    old_mag     = '0;
    src_bin     = '0;
    src_bcd     = '0;
    bcd_adj     = '0;
    bcd_n       = '0;
    bin_n       = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.sample_valid) begin
          sample_d = bus.sample_in;
          state_d  = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          smp           = sample_q[i];
          sign_cap_d[i] = smp[DATA_W-1];
          if (smp == S_MIN) begin
            mag_cap_d[i] = MAG_MAX;
          end else if (smp[DATA_W-1]) begin
            mag_cap_d[i] = ~smp + DATA_W'(1);
          end else begin
            mag_cap_d[i] = smp;
          end
        end
        ch_d    = '0;
        state_d = S_FILTER;
      end

      S_FILTER: begin
        cur_mag = mag_cap_q[ch_q];
`ifdef ACCEL_DEADBAND_EN
        if (cur_mag < DATA_W'(DEADBAND)) begin
          cur_mag           = '0;
          sign_cap_d[ch_q]  = 1'b0;
        end
`endif
        old_mag              = ring_q[ch_q][ptr_q];
        sum_d[ch_q]          = sum_q[ch_q] + SUM_W'(cur_mag) - SUM_W'(old_mag);
        ring_d[ch_q][ptr_q]  = cur_mag;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d    = '0;
          bit_d   = '0;
          ptr_d   = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
          state_d = S_CONVERT;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end

      S_CONVERT: begin
        // First bit of a channel loads the clamped average directly
        if (bit_q == '0) begin
          src_bin          = (avg_c[ch_q] > DISP_MAX) ? DISP_MAX : avg_c[ch_q];
          src_bcd          = '0;
          ovf_res_d[ch_q]  = (avg_c[ch_q] > DISP_MAX);
        end else begin
          src_bin = bin_q;
          src_bcd = bcd_q;
        end
        bcd_adj = src_bcd;
        for (int d = 0; d < DIGITS; d++) begin
          if (src_bcd[d*4 +: 4] >= 4'd5) begin
            bcd_adj[d*4 +: 4] = src_bcd[d*4 +: 4] + 4'd3;
          end
        end
        bcd_n = BCD_W'({bcd_adj, src_bin[DATA_W-1]});
        bin_n = src_bin << 1;
        bin_d = bin_n;
        bcd_d = bcd_n;
        if (bit_q == BIT_W'(DATA_W - 1)) begin
          bcd_res_d[ch_q] = bcd_n;
          bit_d           = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            ch_d       = '0;
            mag_out_d  = avg_c;
            sign_out_d = sign_cap_q;
            bcd_out_d  = bcd_res_d;
            ovf_out_d  = ovf_res_d;
            state_d    = S_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes arriving while a set is in flight are counted, not queued
    if (bus.sample_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset clears history and running sums
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      mag_cap_q   <= '0;
      sign_cap_q  <= '0;
      ring_q      <= '0;
      sum_q       <= '0;
      ptr_q       <= '0;
      ch_q        <= '0;
      bit_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      bcd_res_q   <= '0;
      ovf_res_q   <= '0;
      mag_out_q   <= '0;
      sign_out_q  <= '0;
      bcd_out_q   <= '0;
      ovf_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      mag_cap_q   <= mag_cap_d;
      sign_cap_q  <= sign_cap_d;
      ring_q      <= ring_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      bcd_res_q   <= bcd_res_d;
      ovf_res_q   <= ovf_res_d;
      mag_out_q   <= mag_out_d;
      sign_out_q  <= sign_out_d;
      bcd_out_q   <= bcd_out_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.mag_out   = mag_out_q;
  assign bus.sign_out  = sign_out_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.ovf_out   = ovf_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_accel_channel_conditioner.sv
// Randomized self-checking bench for accel_channel_conditioner against a
// queue-based moving-average / decimal-digit reference model.
module tb_accel_channel_conditioner;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned DEPTH    = 1 << AVG_LOG2;
  localparam int          LAT      = 1 + NUM_CH * (DATA_W + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #20 clk = ~clk;

  accel_channel_conditioner_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

  accel_channel_conditioner #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .DIGITS(DIGITS), .DEADBAND(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: last DEPTH magnitudes per channel, averaged arithmetically
  int                         hist[NUM_CH][$];
  int                         exp_drop;
  logic [NUM_CH*DATA_W-1:0]   exp_mag;
  logic [NUM_CH-1:0]          exp_sign;
  logic [NUM_CH*DIGITS*4-1:0] exp_bcd;
  logic [NUM_CH-1:0]          exp_ovf;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].delete();
      for (int k = 0; k < DEPTH; k++) hist[c].push_back(0);
    end
    exp_drop = 0;
    exp_mag  = '0;
    exp_sign = '0;
    exp_bcd  = '0;
    exp_ovf  = '0;
  endtask

  task automatic model_apply(input logic [NUM_CH*DATA_W-1:0] s);
    for (int c = 0; c < NUM_CH; c++) begin
      logic signed [DATA_W-1:0] sv;
      int val, m, sum, avg, v;
      bit neg;
      sv  = s[c*DATA_W +: DATA_W];
      val = sv;
      neg = (val < 0);
      m   = neg ? -val : val;
      if (m > 32767) m = 32767;
`ifdef ACCEL_DEADBAND_EN
      if (m < 4) begin
        m   = 0;
        neg = 1'b0;
      end
`endif
      hist[c].push_back(m);
      void'(hist[c].pop_front());
      sum = 0;
      foreach (hist[c][k]) sum += hist[c][k];
      avg = sum / DEPTH;
      v   = (avg > 999) ? 999 : avg;
      exp_mag[c*DATA_W +: DATA_W] = DATA_W'(avg);
      exp_sign[c]                 = neg;
      exp_bcd[c*12 +: 12]         = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      exp_ovf[c]                  = (avg > 999);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'($urandom_range(0, 1200));
      3:       return 16'(0) - 16'($urandom_range(1, 1200));
      4:       return 16'($urandom_range(0, 6));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One sample set; drop_at = edge index (after accept) of an extra strobe,
  // LAT+1 places it in the result cycle, -1 means none
  task automatic run_set(input logic [NUM_CH*DATA_W-1:0] s, input int drop_at, input string tag);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    model_apply(s);
    for (int n = 1; n <= LAT + 20 && !seen; n++) begin
      if (n == drop_at) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = {$urandom, $urandom};
        if (exp_drop < 255) exp_drop++;
      end
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      if (n == 1) check_eq({tag, "_busy_early"}, bus.busy, 1);
      if (bus.out_valid) begin
        seen = 1'b1;
        check_eq({tag, "_latency"}, n, LAT);
      end
    end
    check_eq({tag, "_valid_seen"}, seen, 1);
    check_eq({tag, "_mag"}, bus.mag_out, exp_mag);
    check_eq({tag, "_sign"}, bus.sign_out, exp_sign);
    check_eq({tag, "_bcd"}, bus.bcd_out, exp_bcd);
    check_eq({tag, "_ovf"}, bus.ovf_out, exp_ovf);
    check_eq({tag, "_busy_done"}, bus.busy, 1);
    if (drop_at == LAT + 1) begin
      bus.sample_valid = 1'b1;
      if (exp_drop < 255) exp_drop++;
    end
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    check_eq({tag, "_pulse_end"}, bus.out_valid, 0);
    check_eq({tag, "_idle"}, bus.busy, 0);
    check_eq({tag, "_hold_mag"}, bus.mag_out, exp_mag);
    check_eq({tag, "_drop"}, bus.drop_cnt, 8'(exp_drop));
  endtask

  initial begin
    logic [NUM_CH*DATA_W-1:0] s;
    int pulses;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mag", bus.mag_out, 0);
    check_eq("rst_sign", bus.sign_out, 0);
    check_eq("rst_bcd", bus.bcd_out, 0);
    check_eq("rst_ovf", bus.ovf_out, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_drop", bus.drop_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_busy", bus.busy, 0);
    check_eq("post_rst_valid", bus.out_valid, 0);

    // Single set, mixed signs
    s = {16'h0000, 16'hFF9C, 16'h0064};
    run_set(s, -1, "one");
    check_eq("one_mag_const", bus.mag_out, {16'd0, 16'd25, 16'd25});
    check_eq("one_sign_const", bus.sign_out, 3'b010);
    check_eq("one_bcd_const", bus.bcd_out, {12'h000, 12'h025, 12'h025});
    check_eq("one_ovf_const", bus.ovf_out, 0);

    // Average fills up over four sets
    do_reset();
    s = {16'h0000, 16'h0000, 16'h00FA};
    for (int k = 0; k < 4; k++) begin
      run_set(s, -1, "fill");
      repeat (4) @(posedge clk);
    end
    check_eq("fill_mag_x", bus.mag_out[15:0], 250);
    check_eq("fill_bcd_x", bus.bcd_out[11:0], 12'h250);

    // Most-negative saturation and display clamp
    do_reset();
    s = {16'h0000, 16'h0000, 16'h8000};
    for (int k = 0; k < 4; k++) run_set(s, -1, "sat");
    check_eq("sat_mag_x", bus.mag_out[15:0], 32767);
    check_eq("sat_bcd_x", bus.bcd_out[11:0], 12'h999);
    check_eq("sat_ovf_x", bus.ovf_out[0], 1);

    // Strobe while busy and strobe in the result cycle are both dropped
    do_reset();
    s = {16'h0000, 16'h0000, 16'h0064};
    run_set(s, 10, "drop");
    check_eq("drop_cnt_one", bus.drop_cnt, 1);
    check_eq("drop_mag_x", bus.mag_out[15:0], 25);
    run_set(s, LAT + 1, "drop_done");
    check_eq("drop_cnt_two", bus.drop_cnt, 2);

    // Reset in the middle of a set
    do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = {16'h0000, 16'h0000, 16'h0064};
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_valid", bus.out_valid, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check_eq("mid_rst_no_valid", pulses, 0);
    run_set({16'h0000, 16'h0000, 16'h0064}, -1, "after_rst");
    check_eq("after_rst_mag_x", bus.mag_out[15:0], 25);

    // Drop counter saturation under a held strobe
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = '0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    for (int n = 0; n < 100 && bus.busy; n++) @(negedge clk);
    check_eq("sat_drop_idle", bus.busy, 0);
    check_eq("sat_drop_cnt", bus.drop_cnt, 8'hFF);

    // Randomized sets with occasional dropped strobes
    do_reset();
    for (int t = 0; t < 24; t++) begin
      for (int c = 0; c < NUM_CH; c++) s[c*DATA_W +: DATA_W] = rnd_sample();
      run_set(s, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LAT + 1)) : -1, "rnd");
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

`ifdef ACCEL_DEADBAND_EN
    do_reset();
    run_set({16'h0000, 16'h0000, 16'hFFFD}, -1, "db");
    check_eq("db_mag_x", bus.mag_out[15:0], 0);
    check_eq("db_sign_x", bus.sign_out[0], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
